id_ex: RTL and testbench
========================

Name: id_ex

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures every decode output each cycle and presents it to execute one cycle later.
- Detects load-use hazards against the instruction currently in execute, and inserts a one-cycle bubble while requesting upstream stall.
- Flushes to a NOP on a taken jump and freezes on an external hold.

Parameters:
- NOP_INST, 32'h00000013, instruction word loaded on bubble/flush/reset (addi x0,x0,0).
- LOAD_OPCODE, 7'b0000011, opcode identifying loads for hazard detection.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_i  in  32  decoded instruction word.
- inst_addr_i  in  32  instruction address.
- reg1_addr_i  in  5  rs1 index read by decode (0 = unused).
- reg2_addr_i  in  5  rs2 index read by decode (0 = unused).
- reg1_rdata_i / reg2_rdata_i  in  32 each  register operands.
- regw_enable_i  in  1  rd write enable.
- regw_addr_i  in  5  rd index.
- csrw_enable_i  in  1  CSR write enable.
- csrw_data_i / csrw_addr_i  in  32 each  CSR data/address.
- op1_i, op2_i, op1_jump_i, op2_jump_i  in  32 each  ALU and jump operands.
- jump_flag_i  in  1  taken jump/branch from execute.
- hold_i  in  1  external pipeline freeze.
- inst_o … op2_jump_o  out  same widths  registered copies of every *_i data field above (excluding reg*_addr_i).
- valid_o  out  1  1 = real instruction in execute, 0 = bubble.
- stall_o  out  1  combinational load-use stall request to pc/if_id.

Behaviour:
- Reset (rst=1 at edge): inst_o=NOP_INST; all other data outputs 0; regw_enable_o=0; csrw_enable_o=0; valid_o=0. ex_is_load (internal) is cleared to 0.
- Internal state ex_is_load is registered: 1 when the held instruction opcode equals LOAD_OPCODE and its regw_enable is 1.
- Hazard is combinational: hazard = ex_is_load & valid_o & (regw_addr_o≠0) & ((reg1_addr_i≠0 & reg1_addr_i==regw_addr_o) | (reg2_addr_i≠0 & reg2_addr_i==regw_addr_o)).
- stall_o = hazard & ~jump_flag_i & ~rst.
- Per-edge update priority, highest first:
  1. rst: apply the reset values above.
  2. jump_flag_i: load the bubble (NOP_INST, all enables 0, data 0, valid_o=0), regardless of hold_i.
  3. hold_i: all outputs retain their value.
  4. hazard: load the bubble; upstream holds its instruction via stall_o.
  5. Otherwise: capture all *_i inputs and set valid_o=1.
- Latency: exactly 1 cycle from input to output on a normal capture.
- A load-use pair costs exactly one bubble. Next cycle the load has left EX (valid_o=0 bubble), so hazard=0 and the dependent instruction is captured.
- hold_i concurrent with hazard: hold wins. stall_o stays asserted while the hazard persists.
- Instruction writing x0 never triggers a hazard.
- Bubble never asserts regw_enable_o or csrw_enable_o, so execute must treat valid_o=0 as no side effects.
- Reset asserted mid-stall: stall_o drops the same cycle and the register clears at the next edge.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, adds three outputs:
  - bubble_cnt_o (32): increments on each hazard bubble load.
  - flush_cnt_o (32): increments on each jump flush.
  - hold_cnt_o (32): increments on each held cycle.
- Each counter increments once per edge, follows the priority above, resets to 0 on rst and wraps at 2^32−1 → 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 two cycles with random inputs -> inst_o=32'h00000013, valid_o=0, all enables 0, stall_o=0.
- Pass-through: inst_i=32'h00A00093, op2_i=10, regw_addr_i=1 -> next cycle inst_o=32'h00A00093, op2_o=10, regw_addr_o=1, valid_o=1.
- Load-use: EX holds lw x5 (32'h0002A283), then ID reg1_addr_i=5 -> stall_o=1 that cycle; next cycle valid_o=0; cycle after, dependent instruction captured and stall_o=0.
- Load to x0 / no dependency: EX lw x0, ID reg1_addr_i=0 -> stall_o=0, normal capture.
- Flush vs hazard: hazard active and jump_flag_i=1 same cycle -> stall_o=0, next cycle NOP with valid_o=0. With hold_i=1 and jump_flag_i=1 -> flush still occurs.
- Hold: hold_i=1 for 3 cycles with changing inputs -> outputs unchanged; with ID_EX_PERF_CNT_EN, hold_cnt_o=3.

Source files
------------

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode-side fields (*_i) and the registered
// execute-side copies (*_o) plus the valid flag.
interface id_ex_if;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [4:0]  reg1_addr_i;
    logic [4:0]  reg2_addr_i;
    logic [31:0] reg1_rdata_i;
    logic [31:0] reg2_rdata_i;
    logic        regw_enable_i;
    logic [4:0]  regw_addr_i;
    logic        csrw_enable_i;
    logic [31:0] csrw_data_i;
    logic [31:0] csrw_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [31:0] op1_jump_i;
    logic [31:0] op2_jump_i;

    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic        regw_enable_o;
    logic [4:0]  regw_addr_o;
    logic        csrw_enable_o;
    logic [31:0] csrw_data_o;
    logic [31:0] csrw_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] op1_jump_o;
    logic [31:0] op2_jump_o;
    logic        valid_o;

    modport master (
        output inst_i, inst_addr_i, reg1_addr_i, reg2_addr_i, reg1_rdata_i,
               reg2_rdata_i, regw_enable_i, regw_addr_i, csrw_enable_i,
               csrw_data_i, csrw_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i,
        input  inst_o, inst_addr_o, reg1_rdata_o, reg2_rdata_o, regw_enable_o,
               regw_addr_o, csrw_enable_o, csrw_data_o, csrw_addr_o, op1_o,
               op2_o, op1_jump_o, op2_jump_o, valid_o
    );

    modport slave (
        input  inst_i, inst_addr_i, reg1_addr_i, reg2_addr_i, reg1_rdata_i,
               reg2_rdata_i, regw_enable_i, regw_addr_i, csrw_enable_i,
               csrw_data_i, csrw_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i,
        output inst_o, inst_addr_o, reg1_rdata_o, reg2_rdata_o, regw_enable_o,
               regw_addr_o, csrw_enable_o, csrw_data_o, csrw_addr_o, op1_o,
               op2_o, op1_jump_o, op2_jump_o, valid_o
    );
endinterface

// File: rtl/id_ex.sv
// ID/EX pipeline register with load-use bubble, jump flush and hold.
// Optional ID_EX_PERF_CNT_EN adds bubble/flush/hold event counters.
module id_ex #(
    parameter logic [31:0] NOP_INST    = 32'h00000013,
    parameter logic [6:0]  LOAD_OPCODE = 7'b0000011
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus,
    input  logic    jump_flag_i,
    input  logic    hold_i,
    output logic    stall_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] hold_cnt_o
`endif
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] inst_addr;
        logic [31:0] reg1_rdata;
        logic [31:0] reg2_rdata;
        logic        regw_enable;
        logic [4:0]  regw_addr;
        logic        csrw_enable;
        logic [31:0] csrw_data;
        logic [31:0] csrw_addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op1_jump;
        logic [31:0] op2_jump;
    } payload_t;

    payload_t capture_s;
    payload_t bubble_s;
    payload_t payload_nxt_s;
    payload_t payload_r;
    logic     valid_nxt_s;
    logic     valid_r;
    logic     load_nxt_s;
    logic     ex_is_load_r;
    logic     hazard_s;
    logic     rs1_hit_s;
    logic     rs2_hit_s;

    // Hazard detection and next-state selection in priority order.
    always_comb begin
        capture_s.inst        = bus.inst_i;
        capture_s.inst_addr   = bus.inst_addr_i;
        capture_s.reg1_rdata  = bus.reg1_rdata_i;
        capture_s.reg2_rdata  = bus.reg2_rdata_i;
        capture_s.regw_enable = bus.regw_enable_i;
        capture_s.regw_addr   = bus.regw_addr_i;
        capture_s.csrw_enable = bus.csrw_enable_i;
        capture_s.csrw_data   = bus.csrw_data_i;
        capture_s.csrw_addr   = bus.csrw_addr_i;
        capture_s.op1         = bus.op1_i;
        capture_s.op2         = bus.op2_i;
        capture_s.op1_jump    = bus.op1_jump_i;
        capture_s.op2_jump    = bus.op2_jump_i;

        bubble_s      = '0;
        bubble_s.inst = NOP_INST;

        rs1_hit_s = (bus.reg1_addr_i != 5'd0) && (bus.reg1_addr_i == payload_r.regw_addr);
        rs2_hit_s = (bus.reg2_addr_i != 5'd0) && (bus.reg2_addr_i == payload_r.regw_addr);
        hazard_s  = ex_is_load_r & valid_r & (payload_r.regw_addr != 5'd0)
                    & (rs1_hit_s | rs2_hit_s);
        stall_o   = hazard_s & ~jump_flag_i & ~rst;

        payload_nxt_s = payload_r;
        valid_nxt_s   = valid_r;
        load_nxt_s    = ex_is_load_r;
        if (jump_flag_i) begin
            payload_nxt_s = bubble_s;
            valid_nxt_s   = 1'b0;
            load_nxt_s    = 1'b0;
        end else if (hold_i) begin
            payload_nxt_s = payload_r;
            valid_nxt_s   = valid_r;
            load_nxt_s    = ex_is_load_r;
        end else if (hazard_s) begin
            payload_nxt_s = bubble_s;
            valid_nxt_s   = 1'b0;
            load_nxt_s    = 1'b0;
        end else begin
            payload_nxt_s = capture_s;
            valid_nxt_s   = 1'b1;
            load_nxt_s    = (bus.inst_i[6:0] == LOAD_OPCODE) & bus.regw_enable_i;
        end
    end

    // Pipeline register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            payload_r    <= bubble_s;
            valid_r      <= 1'b0;
            ex_is_load_r <= 1'b0;
        end else begin
            payload_r    <= payload_nxt_s;
            valid_r      <= valid_nxt_s;
            ex_is_load_r <= load_nxt_s;
        end
    end

    assign bus.inst_o        = payload_r.inst;
    assign bus.inst_addr_o   = payload_r.inst_addr;
    assign bus.reg1_rdata_o  = payload_r.reg1_rdata;
    assign bus.reg2_rdata_o  = payload_r.reg2_rdata;
    assign bus.regw_enable_o = payload_r.regw_enable;
    assign bus.regw_addr_o   = payload_r.regw_addr;
    assign bus.csrw_enable_o = payload_r.csrw_enable;
    assign bus.csrw_data_o   = payload_r.csrw_data;
    assign bus.csrw_addr_o   = payload_r.csrw_addr;
    assign bus.op1_o         = payload_r.op1;
    assign bus.op2_o         = payload_r.op2;
    assign bus.op1_jump_o    = payload_r.op1_jump;
    assign bus.op2_jump_o    = payload_r.op2_jump;
    assign bus.valid_o       = valid_r;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] flush_cnt_r;
    logic [31:0] hold_cnt_r;

    // Event counters follow the same priority as the register update; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= 32'd0;
            flush_cnt_r  <= 32'd0;
            hold_cnt_r   <= 32'd0;
        end else if (jump_flag_i) begin
            flush_cnt_r  <= flush_cnt_r + 32'd1;
        end else if (hold_i) begin
            hold_cnt_r   <= hold_cnt_r + 32'd1;
        end else if (hazard_s) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bubble_cnt_o = bubble_cnt_r;
    assign flush_cnt_o  = flush_cnt_r;
    assign hold_cnt_o   = hold_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a slot-level model.
module tb_id_ex;

    logic clk;
    logic rst;
    logic jump_flag;
    logic hold;
    logic stall;
    id_ex_if bus();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] hold_cnt;
`endif

    id_ex dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .jump_flag_i (jump_flag),
        .hold_i      (hold),
        .stall_o     (stall)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt_o(bubble_cnt),
        .flush_cnt_o (flush_cnt),
        .hold_cnt_o  (hold_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] inst, inst_addr, rd1, rd2, cdata, caddr, op1, op2, op1j, op2j;
        logic        we, cwe;
        logic [4:0]  rd;
    } slot_t;

    typedef struct {
        logic        rst, jump, hold;
        logic [31:0] inst;
        logic [4:0]  r1, r2, rd;
        logic        we;
        logic [31:0] op2;
        logic        exp_stall, exp_valid;
        logic [31:0] exp_inst;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    slot_t ex_m;
    slot_t nop_slot;
    logic [31:0] bub_m, fl_m, hd_m;
    vec_t  vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t rand_slot();
        slot_t s;
        s.valid = 1'b0;
        s.inst  = $urandom;
        s.inst_addr = $urandom; s.rd1 = $urandom; s.rd2 = $urandom;
        s.cdata = $urandom; s.caddr = $urandom;
        s.op1 = $urandom; s.op2 = $urandom; s.op1j = $urandom; s.op2j = $urandom;
        s.we  = 1'($urandom_range(1)); s.cwe = 1'($urandom_range(1));
        s.rd  = 5'($urandom_range(7));
        return s;
    endfunction

    function automatic vec_t mk(input logic r, j, h, input logic [31:0] inst,
                                input logic [4:0] r1, r2, rd, input logic we,
                                input logic [31:0] op2, input logic es, ev,
                                input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.jump = j; v.hold = h; v.inst = inst; v.r1 = r1; v.r2 = r2;
        v.rd = rd; v.we = we; v.op2 = op2; v.exp_stall = es; v.exp_valid = ev;
        v.exp_inst = ei;
        return v;
    endfunction

    // Load-use rule: EX holds a real load writing a non-zero rd that ID reads.
    function automatic logic model_hazard(input logic [4:0] a, input logic [4:0] b);
        return ex_m.valid && (ex_m.inst[6:0] == 7'b0000011) && ex_m.we &&
               (ex_m.rd != 5'd0) &&
               (((a != 5'd0) && (a == ex_m.rd)) || ((b != 5'd0) && (b == ex_m.rd)));
    endfunction

    task automatic apply(input logic r, j, h, input slot_t s, input logic [4:0] r1, r2,
                         input logic has_exp, input logic es, ev, input logic [31:0] ei);
        logic hz;
        rst = r; jump_flag = j; hold = h;
        bus.inst_i = s.inst; bus.inst_addr_i = s.inst_addr;
        bus.reg1_addr_i = r1; bus.reg2_addr_i = r2;
        bus.reg1_rdata_i = s.rd1; bus.reg2_rdata_i = s.rd2;
        bus.regw_enable_i = s.we; bus.regw_addr_i = s.rd;
        bus.csrw_enable_i = s.cwe; bus.csrw_data_i = s.cdata; bus.csrw_addr_i = s.caddr;
        bus.op1_i = s.op1; bus.op2_i = s.op2; bus.op1_jump_i = s.op1j; bus.op2_jump_i = s.op2j;
        #2;
        hz = model_hazard(r1, r2);
        chk("stall_model", {31'd0, stall}, {31'd0, hz & ~j & ~r});
        if (has_exp) chk("stall_table", {31'd0, stall}, {31'd0, es});
        @(posedge clk);
        if (r) begin
            ex_m = nop_slot; bub_m = 32'd0; fl_m = 32'd0; hd_m = 32'd0;
        end else if (j) begin
            ex_m = nop_slot; fl_m = fl_m + 32'd1;
        end else if (h) begin
            hd_m = hd_m + 32'd1;
        end else if (hz) begin
            ex_m = nop_slot; bub_m = bub_m + 32'd1;
        end else begin
            ex_m = s; ex_m.valid = 1'b1;
        end
        #1;
        chk("valid",       {31'd0, bus.valid_o},       {31'd0, ex_m.valid});
        chk("inst",        bus.inst_o,                 ex_m.inst);
        chk("inst_addr",   bus.inst_addr_o,            ex_m.inst_addr);
        chk("reg1_rdata",  bus.reg1_rdata_o,           ex_m.rd1);
        chk("reg2_rdata",  bus.reg2_rdata_o,           ex_m.rd2);
        chk("regw_enable", {31'd0, bus.regw_enable_o}, {31'd0, ex_m.we});
        chk("regw_addr",   {27'd0, bus.regw_addr_o},   {27'd0, ex_m.rd});
        chk("csrw_enable", {31'd0, bus.csrw_enable_o}, {31'd0, ex_m.cwe});
        chk("csrw_data",   bus.csrw_data_o,            ex_m.cdata);
        chk("csrw_addr",   bus.csrw_addr_o,            ex_m.caddr);
        chk("op1",         bus.op1_o,                  ex_m.op1);
        chk("op2",         bus.op2_o,                  ex_m.op2);
        chk("op1_jump",    bus.op1_jump_o,             ex_m.op1j);
        chk("op2_jump",    bus.op2_jump_o,             ex_m.op2j);
        if (has_exp) begin
            chk("valid_table", {31'd0, bus.valid_o}, {31'd0, ev});
            chk("inst_table",  bus.inst_o, ei);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", bubble_cnt, bub_m);
        chk("flush_cnt",  flush_cnt,  fl_m);
        chk("hold_cnt",   hold_cnt,   hd_m);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        slot_t s;
        s = rand_slot();
        s.inst = v.inst; s.rd = v.rd; s.we = v.we; s.op2 = v.op2;
        apply(v.rst, v.jump, v.hold, s, v.r1, v.r2, 1'b1, v.exp_stall, v.exp_valid, v.exp_inst);
    endtask

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADDI = 32'h00A00093;
    localparam logic [31:0] LW5  = 32'h0002A283;
    localparam logic [31:0] DEP  = 32'h00528313;
    localparam logic [31:0] LW0  = 32'h00002003;
    localparam logic [31:0] ADD2 = 32'h00100113;
    localparam logic [31:0] ADD7 = 32'h005003B3;

    initial begin
        nop_slot = '{valid: 1'b0, inst: NOP, inst_addr: 32'd0, rd1: 32'd0, rd2: 32'd0,
                     cdata: 32'd0, caddr: 32'd0, op1: 32'd0, op2: 32'd0, op1j: 32'd0,
                     op2j: 32'd0, we: 1'b0, cwe: 1'b0, rd: 5'd0};
        ex_m = nop_slot; bub_m = 32'd0; fl_m = 32'd0; hd_m = 32'd0;
        rst = 1'b1; jump_flag = 1'b0; hold = 1'b0;

        //               rst   jump  hold  inst          r1    r2    rd    we    op2     stall valid inst_o
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 5'd5, 5'd3, 5'd5, 1'b1, 32'd7,  1'b0, 1'b0, NOP));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0001A103, 5'd2, 5'd4, 5'd2, 1'b1, 32'd9,  1'b0, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, ADDI,         5'd0, 5'd0, 5'd1, 1'b1, 32'd10, 1'b0, 1'b1, ADDI));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0,  1'b0, 1'b1, LW5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b1, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b0, 1'b1, DEP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW0,          5'd0, 5'd0, 5'd0, 1'b1, 32'd0,  1'b0, 1'b1, LW0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, ADD2,         5'd0, 5'd0, 5'd2, 1'b1, 32'd1,  1'b0, 1'b1, ADD2));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0,  1'b0, 1'b1, LW5));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b0, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0,  1'b0, 1'b1, LW5));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b0, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, ADDI,         5'd0, 5'd0, 5'd1, 1'b1, 32'd10, 1'b0, 1'b1, ADDI));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h00300193, 5'd0, 5'd0, 5'd3, 1'b1, 32'd3,  1'b0, 1'b1, ADDI));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h00400213, 5'd0, 5'd0, 5'd4, 1'b1, 32'd4,  1'b0, 1'b1, ADDI));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h00500293, 5'd0, 5'd0, 5'd5, 1'b0, 32'd5,  1'b0, 1'b1, ADDI));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h00300193, 5'd0, 5'd0, 5'd3, 1'b1, 32'd3,  1'b0, 1'b1, 32'h00300193));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0,  1'b0, 1'b1, LW5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b1, 1'b1, LW5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b1, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b0, 1'b1, DEP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0,  1'b0, 1'b1, LW5));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, DEP,          5'd5, 5'd0, 5'd6, 1'b1, 32'd5,  1'b0, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0,  1'b0, 1'b1, LW5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, ADD7,         5'd0, 5'd5, 5'd7, 1'b1, 32'd0,  1'b1, 1'b0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, ADD7,         5'd0, 5'd5, 5'd7, 1'b1, 32'd0,  1'b0, 1'b1, ADD7));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Chained loads: each dependent costs exactly one bubble.
        run_vec(mk(1'b0, 1'b0, 1'b0, LW5,          5'd5, 5'd0, 5'd5, 1'b1, 32'd0, 1'b0, 1'b1, LW5));
        run_vec(mk(1'b0, 1'b0, 1'b0, 32'h0002A303, 5'd5, 5'd0, 5'd6, 1'b1, 32'd0, 1'b1, 1'b0, NOP));
        run_vec(mk(1'b0, 1'b0, 1'b0, 32'h0002A303, 5'd5, 5'd0, 5'd6, 1'b1, 32'd0, 1'b0, 1'b1, 32'h0002A303));
        run_vec(mk(1'b0, 1'b0, 1'b0, 32'h00130413, 5'd6, 5'd0, 5'd8, 1'b1, 32'd1, 1'b1, 1'b0, NOP));
        run_vec(mk(1'b0, 1'b0, 1'b0, 32'h00130413, 5'd6, 5'd0, 5'd8, 1'b1, 32'd1, 1'b0, 1'b1, 32'h00130413));

        // Randomized traffic with frequent loads and small register indices.
        for (int n = 0; n < 400; n++) begin
            slot_t s;
            logic [31:0] w;
            s = rand_slot();
            w = s.inst;
            if ($urandom_range(1) == 1) w[6:0] = 7'b0000011;
            s.inst = w;
            apply(($urandom_range(99) < 3), ($urandom_range(99) < 10),
                  ($urandom_range(99) < 15), s, 5'($urandom_range(7)),
                  5'($urandom_range(7)), 1'b0, 1'b0, 1'b0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
